branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 105 ++++++++++
 tb/tb_branch_target_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; training happens on the resolve-stage update port.
`timescale 1ns/1ps
module branch_target_buffer #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] if_pc,
  output logic [31:0] pred_pc,
  output logic        pred_hit,
  input  logic        upd_e,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [31:0]        br_cnt_q, br_cnt_d;
  logic [31:0]        mis_cnt_q, mis_cnt_d;

  logic [IDX-1:0]   if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_qual, upd_hit;
  logic             unused_pc_bits;

  assign if_idx  = if_pc[IDX+1:2];
  assign if_tag  = if_pc[31:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[31:IDX+2];
  // Instructions are word aligned, so the byte offset carries no information.
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign pred_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_pc  = (pred_hit && ctr_q[if_idx][1]) ? target_q[if_idx] : if_pc + 32'd4;
  assign br_cnt   = br_cnt_q;
  assign mis_cnt  = mis_cnt_q;

  assign upd_qual = rdy && upd_e;
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // NOTE: every always_comb output gets its default first so no latch is inferred.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_qual) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'd3) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'd0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Taken miss evicts whatever aliases here and starts weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'd2;
      end
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
      if (upd_mispred && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
    end else begin
      valid_q   <= valid_d;
      ctr_q     <= ctr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  // NOTE: tag/target storage is not reset; valid gates it, and skipping the reset keeps it RAM-friendly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios then random
// traffic, checked against a table-level behavioural model.
`timescale 1ns/1ps
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst, rdy, upd_e, upd_taken, upd_mispred;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic [31:0] pred_pc, br_cnt, mis_cnt;
  logic        pred_hit;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_pc(if_pc),
    .pred_pc(pred_pc), .pred_hit(pred_hit),
    .upd_e(upd_e), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: one record per table slot, plain integers for the counter.
  bit          m_valid  [64];
  logic [31:0] m_tagv   [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  logic [31:0] m_br, m_mis;
  bit          m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic exp_t model_lookup(input string name, input logic [31:0] pc);
    exp_t e;
    int   slot;
    slot   = int'((pc / 4) % 64);
    e.name = name;
    e.hit  = m_valid[slot] && (m_tagv[slot] == pc / 256);
    e.pc   = (e.hit && m_ctr[slot] >= 2) ? m_target[slot] : pc + 32'd4;
    e.br   = m_br;
    e.mis  = m_mis;
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit rd, input bit ue, input logic [31:0] upc,
                            input bit tk, input logic [31:0] tgt, input bit mp);
    int slot;
    if (r) begin
      foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_ctr[i] = 0; end
      m_br = 0; m_mis = 0; m_known = 1'b1;
    end else if (rd && ue) begin
      slot = int'((upc / 4) % 64);
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (mp && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (m_valid[slot] && m_tagv[slot] == upc / 256) begin
        if (tk) begin
          m_ctr[slot]    = (m_ctr[slot] + 1 > 3) ? 3 : m_ctr[slot] + 1;
          m_target[slot] = tgt;
        end else begin
          m_ctr[slot] = (m_ctr[slot] - 1 < 0) ? 0 : m_ctr[slot] - 1;
        end
      end else if (tk) begin
        m_valid[slot] = 1'b1; m_tagv[slot] = upc / 256;
        m_target[slot] = tgt; m_ctr[slot] = 2;
      end
    end
  endtask

  // One cycle: drive after the edge, record what the lookup must show now,
  // then advance the model past the coming edge.
  task automatic step(input string name, input bit r, input bit rd, input logic [31:0] ipc,
                      input bit ue, input logic [31:0] upc, input bit tk,
                      input logic [31:0] tgt, input bit mp);
    @(posedge clk); #1;
    rst = r; rdy = rd; if_pc = ipc; upd_e = ue; upd_pc = upc;
    upd_taken = tk; upd_target = tgt; upd_mispred = mp;
    if (m_known) exp_q.push_back(model_lookup(name, ipc));
    model_edge(r, rd, ue, upc, tk, tgt, mp);
  endtask

  task automatic look(input string name, input logic [31:0] ipc);
    step(name, 1'b0, 1'b1, ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input string name, input logic [31:0] pc, input bit tk,
                     input logic [31:0] tgt, input bit mp);
    step(name, 1'b0, 1'b1, pc, 1'b1, pc, tk, tgt, mp);
  endtask

  // Monitor: lookup outputs are valid every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".hit"}, {31'd0, pred_hit}, {31'd0, e.hit});
      check({e.name, ".pc"},  pred_pc, e.pc);
      check({e.name, ".br"},  br_cnt,  e.br);
      check({e.name, ".mis"}, mis_cnt, e.mis);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc, ipc;
    rst = 1'b1; rdy = 1'b1; if_pc = '0; upd_e = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;

    // Reset overrides a concurrent update.
    step("reset", 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    look("after_reset", 32'h100);
    // Allocation: same-cycle lookup sees old contents, next cycle sees target.
    upd("same_cycle_alloc", 32'h100, 1'b1, 32'h200, 1'b1);
    look("alloc_visible", 32'h100);
    // Counter walk down to 0 and saturate, then up to 3 and saturate.
    repeat (3) upd("not_taken", 32'h100, 1'b0, 32'hDEAD_0000, 1'b0);
    look("ctr_zero", 32'h100);
    repeat (4) upd("taken", 32'h100, 1'b1, 32'h240, 1'b1);
    look("ctr_three", 32'h100);
    // Alias eviction at a shared index.
    step("reset2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    upd("alloc_100", 32'h100, 1'b1, 32'h200, 1'b0);
    upd("alias_200", 32'h200, 1'b1, 32'h300, 1'b1);
    look("alias_old", 32'h100);
    look("alias_new", 32'h200);
    // Freeze with rdy low while an update is offered.
    step("frozen", 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    step("frozen2", 1'b0, 1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 32'h900, 1'b1);
    look("after_freeze", 32'h200);
    look("no_alloc_500", 32'h500);
    // Mid-stream reset with an update pending.
    step("mid_reset", 1'b1, 1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1);
    look("mid_reset_chk", 32'h600);
    look("wrap", 32'hFFFF_FFFC);

    // Random traffic confined to few indices/tags so hits and aliases are common.
    for (int n = 0; n < 400; n++) begin
      pc  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      ipc = ($urandom_range(0, 7) == 0) ? $urandom
            : (($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), ipc,
           $urandom_range(0, 1), pc, $urandom_range(0, 1),
           {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 1));
    end

    @(posedge clk); #1;
    upd_e = 1'b0; rst = 1'b0;
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++; checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
